// File: rtl/sub_arbiter_if.sv
// Bundles both requester handshakes, the shared subtractor port and the response bus.
// Latency: none; this is wiring only.
// Backpressure: requests use valid/ready; responses are one-cycle pulses with no ready.
interface sub_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_rs1;
  logic [XLEN-1:0] req0_rs2;
  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_rs1;
  logic [XLEN-1:0] req1_rs2;
  logic [XLEN-1:0] sub_rs1;
  logic [XLEN-1:0] sub_rs2;
  logic            sub_en;
  logic [XLEN-1:0] sub_result;
  logic            rsp0_valid;
  logic            rsp1_valid;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_lt;
  logic            rsp_ltu;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_rs1, req0_rs2,
    input  req1_valid, req1_rs1, req1_rs2,
    input  sub_result,
    output req0_ready, req1_ready,
    output sub_rs1, sub_rs2, sub_en,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_lt, rsp_ltu
  );

  // Requesters plus subtractor side
  modport master (
    output req0_valid, req0_rs1, req0_rs2,
    output req1_valid, req1_rs1, req1_rs2,
    output sub_result,
    input  req0_ready, req1_ready,
    input  sub_rs1, sub_rs2, sub_en,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_lt, rsp_ltu
  );
endinterface

// File: rtl/sub_arbiter.sv
// Round-robin sharing of one subtractor between branch unit (0) and SLT/SLTU path (1).
// Latency: handshake edge N -> subtractor driven in cycle N+1 -> response pulse in cycle N+2.
// Backpressure: readys low during EXEC; responses cannot be stalled, requester must take the pulse.
module sub_arbiter #(
  parameter int XLEN = 32
) (
  input logic          CLK,
  input logic          rst,
  sub_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_rr_ptr;
  logic            r_owner;
  logic [XLEN-1:0] r_op_rs1;
  logic [XLEN-1:0] r_op_rs2;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_lt;
  logic            r_ltu;

  logic            w_window;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_xfer;
  logic            w_gid;
  logic            w_a_msb;
  logic            w_b_msb;
  logic            w_d_msb;
  logic            w_ovf;
  logic            w_lt;
  logic            w_ltu;
  logic            w_zero;

  // Accept window and round-robin grant; readys are forced low while reset is asserted
  always_comb begin
    w_window          = !rst && ((r_state == IDLE) || (r_state == RESP));
    w_grant0          = io_bus.req0_valid && (!io_bus.req1_valid || !r_rr_ptr);
    w_grant1          = io_bus.req1_valid && (!io_bus.req0_valid ||  r_rr_ptr);
    io_bus.req0_ready = w_window && w_grant0;
    io_bus.req1_ready = w_window && w_grant1;
    w_xfer            = (io_bus.req0_valid && io_bus.req0_ready) ||
                        (io_bus.req1_valid && io_bus.req1_ready);
    w_gid             = io_bus.req1_ready;
  end

  // State register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus subtractor drive and response pulses decoded from state
  always_comb begin
    w_next            = r_state;
    io_bus.sub_en     = 1'b0;
    io_bus.sub_rs1    = '0;
    io_bus.sub_rs2    = '0;
    io_bus.rsp0_valid = 1'b0;
    io_bus.rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next = EXEC;
      end
      EXEC: begin
        io_bus.sub_en  = 1'b1;
        io_bus.sub_rs1 = r_op_rs1;
        io_bus.sub_rs2 = r_op_rs2;
        w_next         = RESP;
      end
      RESP: begin
        io_bus.rsp0_valid = !r_owner;
        io_bus.rsp1_valid =  r_owner;
        w_next            = w_xfer ? EXEC : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture and round-robin pointer update on each accepted request
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_op_rs1 <= '0;
      r_op_rs2 <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= ~w_gid;
      r_owner  <= w_gid;
      r_op_rs1 <= w_gid ? io_bus.req1_rs1 : io_bus.req0_rs1;
      r_op_rs2 <= w_gid ? io_bus.req1_rs2 : io_bus.req0_rs2;
    end
  end

  // Compare flags derived from operand sign bits and the difference
  always_comb begin
    w_a_msb = r_op_rs1[XLEN-1];
    w_b_msb = r_op_rs2[XLEN-1];
    w_d_msb = io_bus.sub_result[XLEN-1];
    w_ovf   = (w_a_msb ^ w_b_msb) & (w_a_msb ^ w_d_msb);
    w_lt    = w_d_msb ^ w_ovf;
    w_ltu   = (~w_a_msb & w_b_msb) | (~(w_a_msb ^ w_b_msb) & w_d_msb);
    w_zero  = (io_bus.sub_result == '0);
  end

  // Capture difference and flags at the edge closing EXEC; held until the next capture
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result <= io_bus.sub_result;
      r_zero   <= w_zero;
      r_lt     <= w_lt;
      r_ltu    <= w_ltu;
    end
  end

  // Response bus is driven straight from the capture registers
  always_comb begin
    io_bus.rsp_result = r_result;
    io_bus.rsp_zero   = r_zero;
    io_bus.rsp_lt     = r_lt;
    io_bus.rsp_ltu    = r_ltu;
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: table vectors, alternating grants, back-to-back and reset-in-EXEC.
// Latency: responses are expected exactly two cycles after the handshake cycle.
// Backpressure: requesters hold valid until ready; responses are consumed on the pulse.
`timescale 1ns/1ps
module tb_sub_arbiter;
  localparam int XLEN = 32;

  logic CLK = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sub_arbiter_if #(.XLEN(XLEN)) bus ();
  sub_arbiter #(.XLEN(XLEN)) dut (.CLK(CLK), .rst(rst), .io_bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Behavioural subtractor, En-gated
  assign bus.sub_result = bus.sub_en ? (bus.sub_rs1 - bus.sub_rs2) : '0;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ltu;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ltu;
  } vec_t;

  exp_t sb_q[$];
  logic hs_id_q[$];
  int   hs_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id   = id;
    e.res  = a - b;
    e.zero = (a == b);
    e.lt   = ($signed(a) < $signed(b));
    e.ltu  = (a < b);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_rs1 = a; bus.req0_rs2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_rs1 = a; bus.req1_rs2 = b;
    end
  endtask

  // Present one op, wait (bounded) for ready, push the expectation; returns 1ns after the transfer edge
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int   n;
    logic rdy;
    bit   done;
    n    = 0;
    done = 0;
    set_req(id, 1'b1, a, b);
    while (!done) begin
      @(negedge CLK);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      if (rdy) begin
        e.id  = id;
        e.cyc = cyc + 2;
        sb_q.push_back(e);
        hs_id_q.push_back(id);
        hs_cyc_q.push_back(cyc);
        done = 1;
      end else begin
        n++;
        if (n > 50) begin
          errors++; checks++;
          $display("FAIL handshake_timeout: requester %0d got no ready in 50 cycles, required ready", id);
          done = 1;
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge CLK); n++;
    end
    #1;
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: subtractor drive, ready/rsp exclusivity, result hold, scoreboard compare
  logic        exec_exp = 1'b0;
  logic [31:0] exp_op1, exp_op2, res_prev;
  logic        pulse_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (rst) begin
      exec_exp   = 1'b0;
      pulse_prev = 1'b0;
    end else begin
      chk("sub_en", bus.sub_en, exec_exp);
      if (exec_exp) begin
        chk("sub_rs1", bus.sub_rs1, exp_op1);
        chk("sub_rs2", bus.sub_rs2, exp_op2);
      end else begin
        chk("sub_ops_quiet", bus.sub_rs1 | bus.sub_rs2, 0);
      end
      if (bus.req0_ready || bus.req1_ready)
        chk("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
      if (pulse_prev)
        chk("rsp_hold", bus.rsp_result, res_prev);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 0);
        if (sb_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b, required no pulse", bus.rsp0_valid, bus.rsp1_valid);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id",     bus.rsp1_valid, e.id);
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_zero",   bus.rsp_zero, e.zero);
          chk("rsp_lt",     bus.rsp_lt, e.lt);
          chk("rsp_ltu",    bus.rsp_ltu, e.ltu);
          chk("rsp_cycle",  cyc, e.cyc);
        end
      end
      pulse_prev = bus.rsp0_valid | bus.rsp1_valid;
      res_prev   = bus.rsp_result;
      exec_exp   = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
      if (exec_exp) begin
        exp_op1 = bus.req0_ready ? bus.req0_rs1 : bus.req1_rs1;
        exp_op2 = bus.req0_ready ? bus.req0_rs2 : bus.req1_rs2;
      end
    end
  end

  vec_t        tbl[6];
  logic [31:0] ra[2][4];
  logic [31:0] rb[2][4];

  initial begin
    tbl[0] = '{1'b0, 32'd5,          32'd3,          32'h00000002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'd3,          32'd5,          32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 32'h80000000,   32'h00000001,   32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h1234ABCD,   32'h1234ABCD,   32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        ra[r][i] = $urandom;
        rb[r][i] = $urandom;
      end

    // Reset state, with req0 valid held so the ready gating is exercised
    rst = 1'b1;
    set_req(0, 1'b1, 32'd7, 32'd1);
    set_req(1, 1'b0, 32'd0, 32'd0);
    #12;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_sub_en",     bus.sub_en, 0);
    chk("rst_sub_rs1",    bus.sub_rs1, 0);
    chk("rst_rsp_valid",  {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_flags",  {bus.rsp_zero, bus.rsp_lt, bus.rsp_ltu}, 0);
    set_req(0, 1'b0, 32'd0, 32'd0);
    @(posedge CLK); #1;
    rst = 1'b0;
    @(posedge CLK); #1;

    // Both requesters valid continuously: grants alternate 0,1,0,1 every 2 cycles
    hs_id_q.delete(); hs_cyc_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_op(0, ra[0][i], rb[0][i], model(0, ra[0][i], rb[0][i]));
        set_req(0, 1'b0, 32'd0, 32'd0);
      end
      begin
        for (int i = 0; i < 4; i++) do_op(1, ra[1][i], rb[1][i], model(1, ra[1][i], rb[1][i]));
        set_req(1, 1'b0, 32'd0, 32'd0);
      end
    join
    drain();
    chk("alt_hs_count", hs_id_q.size(), 8);
    for (int i = 1; i < hs_id_q.size(); i++) begin
      chk("alt_grant_id", hs_id_q[i], i % 2);
      chk("alt_spacing",  hs_cyc_q[i] - hs_cyc_q[i-1], 2);
    end
    if (hs_id_q.size() > 0) chk("alt_first_grant", hs_id_q[0], 0);

    // Table vectors, one isolated op at a time
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.id = tbl[i].id; e.res = tbl[i].res; e.zero = tbl[i].zero;
      e.lt = tbl[i].lt; e.ltu = tbl[i].ltu; e.cyc = 0;
      do_op(tbl[i].id, tbl[i].rs1, tbl[i].rs2, e);
      set_req(tbl[i].id, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge CLK);
      #1;
    end
    drain();

    // Back-to-back on requester 0: second ready lands in the RESP cycle of the first op
    hs_id_q.delete(); hs_cyc_q.delete();
    do_op(0, 32'd100, 32'd1,   model(0, 32'd100, 32'd1));
    do_op(0, 32'd1,   32'd100, model(0, 32'd1, 32'd100));
    do_op(0, 32'h55,  32'h55,  model(0, 32'h55, 32'h55));
    set_req(0, 1'b0, 32'd0, 32'd0);
    drain();
    chk("b2b_hs_count", hs_cyc_q.size(), 3);
    for (int i = 1; i < hs_cyc_q.size(); i++)
      chk("b2b_spacing", hs_cyc_q[i] - hs_cyc_q[i-1], 2);

    // Reset asserted during EXEC: outputs drop at once, no pulse, pointer back to requester 0
    do_op(0, 32'h40, 32'h4, model(0, 32'h40, 32'h4));
    set_req(0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_sub_en",     bus.sub_en, 0);
    chk("mid_rst_sub_rs1",    bus.sub_rs1, 0);
    chk("mid_rst_rsp_valid",  {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("mid_rst_rsp_result", bus.rsp_result, 0);
    chk("mid_rst_flags",      {bus.rsp_zero, bus.rsp_lt, bus.rsp_ltu}, 0);
    sb_q.delete();
    @(posedge CLK); #1;
    rst = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    hs_id_q.delete(); hs_cyc_q.delete();
    fork
      do_op(0, 32'd9, 32'd2, model(0, 32'd9, 32'd2));
      do_op(1, 32'd2, 32'd9, model(1, 32'd2, 32'd9));
    join
    set_req(0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0);
    drain();
    chk("post_rst_hs_count", hs_id_q.size(), 2);
    if (hs_id_q.size() > 0) chk("post_rst_first_grant", hs_id_q[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200us, required completion");
    $fatal(1, "timeout");
  end

endmodule
